// File: rtl/ysyx_22040632_dcache_pkg.sv
// Shared dcache constants and types: geometry, flush-walker state encoding and line address type.
package ysyx_22040632_dcache_pkg;

    localparam int SETS  = 32;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 21;
    localparam int OFF_W = 6;
    localparam int LINES = 2 * SETS;
    localparam int CNT_W = $clog2(LINES + 1);

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, INVAL, DONE} flush_state_t;

    typedef logic [TAG_W+IDX_W+OFF_W-1:0] line_addr_t;

    function automatic line_addr_t make_line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ysyx_22040632_dirty_pick.sv
// Lowest-first priority pick over the pending dirty mask: set-major, way 0 before way 1.
module ysyx_22040632_dirty_pick
    import ysyx_22040632_dcache_pkg::*;
(
    input  logic [LINES-1:0] pending,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic             way
);

    // Scan from the top down so the last hit written is the lowest (set, way) key.
    always_comb begin
        any = |pending;
        idx = '0;
        way = 1'b0;
        for (int i = SETS - 1; i >= 0; i--) begin
            if (pending[SETS+i]) begin
                idx = IDX_W'(i);
                way = 1'b1;
            end
            if (pending[i]) begin
                idx = IDX_W'(i);
                way = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040632_dcache_flush_walker.sv
// Dcache flush sequencer: snapshots dirty bits, writes back each dirty line in order, then clears the tags.
module ysyx_22040632_dcache_flush_walker
    import ysyx_22040632_dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rrst_n,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    input  logic [SETS-1:0]  dirty_arr_0,
    input  logic [SETS-1:0]  dirty_arr_1,
    output logic [IDX_W-1:0] tag_index,
    output logic             tag_way,
    input  logic [TAG_W-1:0] tag_read,
    output logic             wb_valid,
    input  logic             wb_ready,
    output line_addr_t       wb_addr,
    output logic             wb_way,
    input  logic             wb_done,
    output logic             flush_tag_f,
    output logic [CNT_W-1:0] wb_cnt
);

    flush_state_t     state;
    logic [LINES-1:0] pending;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_way;
    logic [IDX_W:0]   pick_bit;

    ysyx_22040632_dirty_pick u_pick (
        .pending (pending),
        .any     (pick_any),
        .idx     (pick_idx),
        .way     (pick_way)
    );

    // Way is the MSB of the pending bit index because SETS is a power of two.
    assign pick_bit = {pick_way, pick_idx};

    // tag_read is only meaningful while a request is presented; keep the bus at zero otherwise.
    assign wb_addr = wb_valid ? make_line_addr(tag_read, tag_index) : '0;
    assign wb_way  = tag_way;

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= IDLE;
            pending     <= '0;
            tag_index   <= '0;
            tag_way     <= 1'b0;
            wb_cnt      <= '0;
            flush_busy  <= 1'b0;
            flush_done  <= 1'b0;
            wb_valid    <= 1'b0;
            flush_tag_f <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        pending    <= {dirty_arr_1, dirty_arr_0};
                        wb_cnt     <= '0;
                        flush_busy <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!pick_any) begin
                        flush_tag_f <= 1'b1;
                        state       <= INVAL;
                    end else begin
                        tag_index         <= pick_idx;
                        tag_way           <= pick_way;
                        pending[pick_bit] <= 1'b0;
                        wb_valid          <= 1'b1;
                        state             <= REQ;
                    end
                end
                REQ: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_cnt   <= wb_cnt + CNT_W'(1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wb_done) begin
                        state <= SCAN;
                    end
                end
                INVAL: begin
                    flush_tag_f <= 1'b0;
                    flush_done  <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    flush_done <= 1'b0;
                    flush_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_dcache_flush_walker.sv
// Randomized scoreboard bench for the dcache flush walker with a behavioural write-back engine.
module tb_ysyx_22040632_dcache_flush_walker;
    import ysyx_22040632_dcache_pkg::*;

    logic             clk = 1'b0;
    logic             rrst_n;
    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;
    logic [SETS-1:0]  dirty_arr_0;
    logic [SETS-1:0]  dirty_arr_1;
    logic [IDX_W-1:0] tag_index;
    logic             tag_way;
    logic [TAG_W-1:0] tag_read;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_addr;
    logic             wb_way;
    logic             wb_done;
    logic             flush_tag_f;
    logic [CNT_W-1:0] wb_cnt;

    logic [TAG_W-1:0] tag_mem [2][SETS];
    assign tag_read = tag_mem[tag_way][tag_index];

    ysyx_22040632_dcache_flush_walker dut (
        .clk         (clk),
        .rrst_n      (rrst_n),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done),
        .dirty_arr_0 (dirty_arr_0),
        .dirty_arr_1 (dirty_arr_1),
        .tag_index   (tag_index),
        .tag_way     (tag_way),
        .tag_read    (tag_read),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_way      (wb_way),
        .wb_done     (wb_done),
        .flush_tag_f (flush_tag_f),
        .wb_cnt      (wb_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];
    int ftf_cnt  = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    int stall_cfg = 0;
    int dly_cfg   = 1;
    bit spur_en   = 1'b0;
    bit poke_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference order: every dirty (set, way) in ascending set, way 0 first.
    task automatic build_expect(input logic [31:0] a0, input logic [31:0] a1, output int n);
        logic dirty;
        logic [4:0] s5;
        exp_q.delete();
        n = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                dirty = (w == 0) ? a0[s] : a1[s];
                s5 = s[4:0];
                if (dirty) begin
                    exp_q.push_back({w[0], tag_mem[w][s], s5, 6'b0});
                    n++;
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks request stability.
    initial begin
        logic        stall_prev;
        logic [31:0] addr_prev;
        logic        way_prev;
        logic [32:0] e;
        stall_prev = 1'b0;
        addr_prev  = '0;
        way_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (rrst_n === 1'b1) begin
                if (stall_prev) begin
                    check("req_hold_valid", 64'(wb_valid), 64'd1);
                    check("req_hold_addr", 64'(wb_addr), 64'(addr_prev));
                    check("req_hold_way", 64'(wb_way), 64'(way_prev));
                end
                if (wb_valid && wb_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected actual=%0h required=none", wb_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_addr", 64'(wb_addr), 64'(e[31:0]));
                        check("wb_way", 64'(wb_way), 64'(e[32]));
                    end
                end
                if (flush_tag_f) begin
                    ftf_cnt++;
                    check("inval_after_all_wb", 64'(exp_q.size()), 64'd0);
                end
                if (flush_done) done_cnt++;
                stall_prev = wb_valid && !wb_ready;
                addr_prev  = wb_addr;
                way_prev   = wb_way;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Write-back engine model: stalls ready, returns wb_done after a delay, optional spurious events.
    initial begin
        int cnt;
        int stall_left;
        bit seen;
        bit hs_prev;
        bit poke;
        cnt = 0; stall_left = 0; seen = 0; hs_prev = 0; poke = 0;
        wb_ready = 1'b0;
        wb_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wb_done = 1'b0;
            if (poke) begin
                flush_req = 1'b0;
                poke = 0;
            end
            if (rrst_n !== 1'b1) begin
                hs_prev = 0;
                seen = 0;
            end
            if (hs_prev) begin
                cnt  = (dly_cfg > 0) ? dly_cfg : int'($urandom_range(1, 3));
                seen = 0;
                if (poke_en) begin
                    flush_req = 1'b1;
                    poke = 1;
                end
            end
            if (cnt == 1) wb_done = 1'b1;
            if (cnt > 0) cnt--;
            if (wb_valid && !seen) begin
                seen = 1;
                stall_left = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
            end
            wb_ready = seen && (stall_left == 0);
            if (seen && stall_left > 0) stall_left--;
            if (spur_en && wb_valid && cnt == 0 && $urandom_range(0, 1) == 1) wb_done = 1'b1;
            hs_prev = wb_valid && wb_ready && (rrst_n === 1'b1);
        end
    end

    task automatic new_tags();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++)
                tag_mem[w][s] = TAG_W'($urandom);
    endtask

    task automatic start_flush(input logic [31:0] a0, input logic [31:0] a1, output int n);
        new_tags();
        dirty_arr_0 = a0;
        dirty_arr_1 = a1;
        build_expect(a0, a1, n);
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        // Snapshot already taken: later changes must not matter.
        dirty_arr_0 = ~a0;
        dirty_arr_1 = ~a1;
    endtask

    task automatic run_flush(input string name, input logic [31:0] a0, input logic [31:0] a1,
                             input int stall, input int dly, input bit spur, input bit poke);
        int n, ftf0, done0, h0, c;
        stall_cfg = stall;
        dly_cfg   = dly;
        spur_en   = spur;
        poke_en   = poke;
        ftf0  = ftf_cnt;
        done0 = done_cnt;
        h0    = hs_cnt;
        start_flush(a0, a1, n);
        c = 0;
        while (done_cnt == done0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (done_cnt == done0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        check({name, "_busy_idle"}, 64'(flush_busy), 64'd0);
        check({name, "_wb_cnt"}, 64'(wb_cnt), 64'(n));
        check({name, "_handshakes"}, 64'(hs_cnt - h0), 64'(n));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_inval_pulses"}, 64'(ftf_cnt - ftf0), 64'd1);
        check({name, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
        check({name, "_wb_cnt_hold"}, 64'(wb_cnt), 64'(n));
        spur_en = 1'b0;
        poke_en = 1'b0;
    endtask

    initial begin
        int n, h0, ftf0, done0, c;
        rrst_n      = 1'b0;
        flush_req   = 1'b0;
        dirty_arr_0 = '0;
        dirty_arr_1 = '0;
        new_tags();

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(flush_busy), 64'd0);
        check("rst_done", 64'(flush_done), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_tag_index", 64'(tag_index), 64'd0);
        check("rst_tag_way", 64'(tag_way), 64'd0);
        check("rst_flush_tag_f", 64'(flush_tag_f), 64'd0);
        check("rst_wb_cnt", 64'(wb_cnt), 64'd0);
        @(posedge clk); #1;
        rrst_n = 1'b1;
        repeat (2) @(posedge clk);

        // No dirty lines: flush_req in cycle 0, inval in cycle 2, done in cycle 3.
        exp_q.delete();
        #1;
        flush_req = 1'b1;
        @(negedge clk);
        check("lat_c0_ftf", 64'(flush_tag_f), 64'd0);
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(negedge clk);
        check("lat_c1_busy", 64'(flush_busy), 64'd1);
        check("lat_c1_ftf", 64'(flush_tag_f), 64'd0);
        @(negedge clk);
        check("lat_c2_ftf", 64'(flush_tag_f), 64'd1);
        check("lat_c2_done", 64'(flush_done), 64'd0);
        @(negedge clk);
        check("lat_c3_ftf", 64'(flush_tag_f), 64'd0);
        check("lat_c3_done", 64'(flush_done), 64'd1);
        @(negedge clk);
        check("lat_c4_busy", 64'(flush_busy), 64'd0);
        check("lat_c4_wb_cnt", 64'(wb_cnt), 64'd0);

        run_flush("three_lines", 32'h0000_0005, 32'h0000_0004, 0, 2, 1'b0, 1'b0);
        run_flush("ready_stall", 32'h8000_0001, 32'h0000_0100, 5, 1, 1'b0, 1'b0);
        run_flush("all_dirty", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0, 1'b0);
        run_flush("ignored_events", $urandom, $urandom, -1, 2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            run_flush("random", $urandom & $urandom, $urandom, -1, -1, 1'b0, 1'b0);

        // Reset in WAIT of the second write-back.
        stall_cfg = 0;
        dly_cfg   = 8;
        h0    = hs_cnt;
        ftf0  = ftf_cnt;
        done0 = done_cnt;
        start_flush(32'h0000_0013, 32'h0000_0000, n);
        c = 0;
        while (hs_cnt < h0 + 2 && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("abort_reached_second_wb", 64'(hs_cnt - h0), 64'd2);
        rrst_n = 1'b0;
        #1;
        check("abort_busy", 64'(flush_busy), 64'd0);
        check("abort_wb_valid", 64'(wb_valid), 64'd0);
        check("abort_wb_addr", 64'(wb_addr), 64'd0);
        check("abort_tag_index", 64'(tag_index), 64'd0);
        check("abort_tag_way", 64'(tag_way), 64'd0);
        check("abort_wb_cnt", 64'(wb_cnt), 64'd0);
        check("abort_done", 64'(flush_done), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_inval", 64'(ftf_cnt - ftf0), 64'd0);
        check("abort_no_done", 64'(done_cnt - done0), 64'd0);
        rrst_n = 1'b1;
        exp_q.delete();
        run_flush("after_abort", 32'h0000_2200, 32'h0040_0001, -1, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
